fifo_access_ctrl: RTL and testbench

//  Shares the 16x16 shift-register FIFO between two write requesters, A and B, using

---
 rtl/fifo_access_ctrl.sv | 141 ++++++++++++++
 tb/tb_fifo_access_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_access_ctrl.sv
// rtl/fifo_access_ctrl.sv - round-robin two-writer access controller and drain port for a 16-deep FIFO
// Keeps a shadow occupancy so write/read requests to the FIFO never overflow or underflow it.
module fifo_access_ctrl #(
    parameter int FIFO_DEEP = 16,
    parameter int DATA_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ack,
    input  logic              b_req,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ack,
    output logic              fifo_write_req,
    output logic [DATA_W-1:0] fifo_write_data,
    output logic              fifo_read_req,
    input  logic [DATA_W-1:0] fifo_read_data,
    input  logic [4:0]        fifo_left_sig,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [4:0]        occ,
    output logic              sync_err
);

    localparam logic [4:0] DEEP = 5'(FIFO_DEEP);

    typedef enum logic [1:0] {IDLE, RD, CAP, HOLD} rd_state_e;

    rd_state_e         state_q, state_d;
    logic [4:0]        occ_q, occ_d;
    logic [4:0]        occ_d1_q, occ_d1_d;
    logic              rr_last_q, rr_last_d;
    logic              wr_req_q, wr_req_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              rd_req_q, rd_req_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              chk_en_q, chk_en_d;
    logic              sync_err_q, sync_err_d;

    logic can_write;
    logic grant_a;
    logic grant_b;
    logic rd_dec;

    always_comb begin
        can_write = (occ_q < DEEP);
        // rr_last_q = 1 means B was granted last. Acks are held off while in
        // reset so no requester believes a word was taken that reset will drop.
        grant_a = !rst_n && can_write && a_req && (!b_req || rr_last_q);
        grant_b = !rst_n && can_write && b_req && (!a_req || !rr_last_q);

        state_d    = state_q;
        out_data_d = out_data_q;
        rd_dec     = 1'b0;
        case (state_q)
            IDLE: begin
                if (occ_q != 5'd0) begin
                    state_d = RD;
                    rd_dec  = 1'b1;
                end
            end
            RD:  state_d = CAP;
            CAP: begin
                state_d    = HOLD;
                out_data_d = fifo_read_data;
            end
            HOLD: begin
                if (out_ready) begin
                    if (occ_q != 5'd0) begin
                        state_d = RD;
                        rd_dec  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        rd_req_d    = (state_d == RD);
        out_valid_d = (state_d == HOLD);

        occ_d = occ_q;
        if ((grant_a || grant_b) && !rd_dec) begin
            occ_d = occ_q + 5'd1;
        end else if (!(grant_a || grant_b) && rd_dec) begin
            occ_d = occ_q - 5'd1;
        end

        wr_req_d  = grant_a || grant_b;
        wr_data_d = grant_a ? a_data : (grant_b ? b_data : wr_data_q);
        rr_last_d = grant_a ? 1'b0 : (grant_b ? 1'b1 : rr_last_q);

        // The FIFO's own count trails occ by one cycle, hence the delayed copy.
        occ_d1_d   = occ_q;
        chk_en_d   = 1'b1;
        sync_err_d = sync_err_q || (chk_en_q && (fifo_left_sig != (DEEP - occ_d1_q)));
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= IDLE;
            occ_q       <= 5'd0;
            occ_d1_q    <= 5'd0;
            rr_last_q   <= 1'b1;
            wr_req_q    <= 1'b0;
            wr_data_q   <= '0;
            rd_req_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            chk_en_q    <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            occ_q       <= occ_d;
            occ_d1_q    <= occ_d1_d;
            rr_last_q   <= rr_last_d;
            wr_req_q    <= wr_req_d;
            wr_data_q   <= wr_data_d;
            rd_req_q    <= rd_req_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            chk_en_q    <= chk_en_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign a_ack           = grant_a;
    assign b_ack           = grant_b;
    assign fifo_write_req  = wr_req_q;
    assign fifo_write_data = wr_data_q;
    assign fifo_read_req   = rd_req_q;
    assign out_valid       = out_valid_q;
    assign out_data        = out_data_q;
    assign occ             = occ_q;
    assign sync_err        = sync_err_q;

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// tb/tb_fifo_access_ctrl.sv - scoreboard bench for fifo_access_ctrl with a queue-based FIFO model
module tb_fifo_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        a_req = 1'b0, b_req = 1'b0, out_ready = 1'b0;
    logic [15:0] a_data = '0, b_data = '0;
    logic        a_ack, b_ack, fifo_write_req, fifo_read_req, out_valid, sync_err;
    logic [15:0] fifo_write_data, fifo_read_data, out_data;
    logic [4:0]  fifo_left_sig, occ;
    bit          force_left = 1'b0;
    bit          sync_expect = 1'b0;

    int n_pass = 0;
    int n_fail = 0;

    logic [15:0] fq[$];
    logic [4:0]  fifo_cnt = 5'd0;
    logic [15:0] fifo_rd_q = '0;
    int          fpre;

    logic [15:0] expq[$];

    always #5 clk = ~clk;

    fifo_access_ctrl #(.FIFO_DEEP(16), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_data(a_data), .a_ack(a_ack),
        .b_req(b_req), .b_data(b_data), .b_ack(b_ack),
        .fifo_write_req(fifo_write_req), .fifo_write_data(fifo_write_data),
        .fifo_read_req(fifo_read_req), .fifo_read_data(fifo_read_data),
        .fifo_left_sig(fifo_left_sig),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .occ(occ), .sync_err(sync_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural 16-deep FIFO: registered read data, left_sig = free slots.
    assign fifo_read_data = fifo_rd_q;
    assign fifo_left_sig  = force_left ? 5'd5 : (5'd16 - fifo_cnt);

    always @(posedge clk) begin
        if (rst_n) begin
            fq.delete();
            fifo_cnt  <= 5'd0;
            fifo_rd_q <= '0;
        end else begin
            fpre = fq.size();
            if (fifo_read_req) begin
                check("fifo_read_not_empty", fpre != 0, 1);
                if (fq.size() != 0) fifo_rd_q <= fq.pop_front();
            end
            if (fifo_write_req) begin
                check("fifo_write_not_full", fpre < 16, 1);
                if (fpre < 16) fq.push_back(fifo_write_data);
            end
            fifo_cnt <= 5'(fq.size());
        end
    end

    // Monitor / scoreboard.
    int          exp_occ;
    bit          can_w, ea, eb;
    bit          last_b = 1'b1;
    bit          prev_stall = 1'b0, have_hs = 1'b0, ready_cont = 1'b0;
    logic [15:0] prev_data = '0;
    int          cyc = 0, hs_cyc = 0, hs_occ = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            expq.delete();
            last_b     = 1'b1;
            prev_stall = 1'b0;
            have_hs    = 1'b0;
            ready_cont = 1'b0;
        end else begin
            exp_occ = int'(fifo_cnt) + int'(fifo_write_req) - int'(fifo_read_req);
            check("occ", occ, exp_occ);
            can_w = (exp_occ < 16);
            ea = can_w && a_req && (!b_req || last_b);
            eb = can_w && b_req && (!a_req || !last_b);
            check("a_ack", a_ack, ea);
            check("b_ack", b_ack, eb);
            if (ea) begin expq.push_back(a_data); last_b = 1'b0; end
            if (eb) begin expq.push_back(b_data); last_b = 1'b1; end
            if (out_valid) check("no_read_in_hold", fifo_read_req, 0);
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    n_fail++;
                    $display("FAIL out_data: got 0x%0h, expected no word", out_data);
                end else begin
                    check("out_data", out_data, expq.pop_front());
                end
                if (have_hs && ready_cont && hs_occ > 0) check("throughput", cyc - hs_cyc, 3);
                have_hs    = 1'b1;
                hs_cyc     = cyc;
                hs_occ     = exp_occ;
                ready_cont = 1'b1;
            end else if (!out_ready) begin
                ready_cont = 1'b0;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (!sync_expect) check("sync_err", sync_err, 0);
        end
    end

    bit a_took, b_took, rd_seen, ov_seen, wr_seen;

    task automatic cycle();
        @(negedge clk);
        a_took  = a_req && a_ack;
        b_took  = b_req && b_ack;
        rd_seen = fifo_read_req;
        ov_seen = out_valid;
        wr_seen = fifo_write_req;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b1; a_req = 1'b0; b_req = 1'b0; out_ready = 1'b0; force_left = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b0;
    endtask

    task automatic drain(input string tag);
        int  idle = 0;
        bit  done = 1'b0;
        out_ready = 1'b1; a_req = 1'b0; b_req = 1'b0;
        for (int k = 0; k < 400; k++) begin
            cycle();
            if (occ == 5'd0 && !out_valid) idle++; else idle = 0;
            if (idle >= 4) begin done = 1'b1; break; end
        end
        check({tag, "_drain_done"}, done, 1);
        check({tag, "_scoreboard_empty"}, expq.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, first_ack, last_ack, first_ov, wr_cnt, ga, gb, rd_cnt;
        bit first, v, found;

        do_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_occ", occ, 0);
        check("rst_wr_req", fifo_write_req, 0);
        check("rst_rd_req", fifo_read_req, 0);
        check("rst_out_data", out_data, 0);
        check("rst_wr_data", fifo_write_data, 0);
        check("rst_sync_err", sync_err, 0);

        // A alone, six back-to-back words, consumer stalled.
        a_req = 1'b1; a_data = 16'h1111;
        n = 0; first_ack = -1; last_ack = -1; first_ov = -1; wr_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (a_took) begin
                if (first_ack < 0) first_ack = k;
                last_ack = k; n++; a_data++;
                if (n == 6) a_req = 1'b0;
            end
            if (ov_seen && first_ov < 0) first_ov = k;
            if (wr_seen) wr_cnt++;
        end
        check("t1_acks", n, 6);
        check("t1_first_ack", first_ack, 0);
        check("t1_ack_span", last_ack - first_ack, 5);
        check("t1_latency", first_ov - first_ack, 4);
        check("t1_wr_cycles", wr_cnt, 6);
        check("t1_occ", occ, 5);
        drain("t1");

        // Both requesters, no drain: alternate from A until full.
        do_reset();
        a_req = 1'b1; b_req = 1'b1; a_data = 16'h1111; b_data = 16'h2221;
        ga = 0; gb = 0; first = 1'b1;
        for (int k = 0; k < 60; k++) begin
            cycle();
            if (first && (a_took || b_took)) begin
                check("t2_first_grant_a", {a_took, b_took}, 2'b10);
                first = 1'b0;
            end
            if (a_took) begin ga++; a_data++; end
            if (b_took) begin gb++; b_data++; end
        end
        check("t2_grants_a", ga, 9);
        check("t2_grants_b", gb, 8);
        check("t2_occ_full", occ, 16);
        check("t2_a_ack_low", a_ack, 0);
        check("t2_b_ack_low", b_ack, 0);

        // Full in HOLD, A waiting, consumer takes a word.
        b_req = 1'b0; out_ready = 1'b1;
        cycle();
        check("t4_no_ack_at_full", a_took, 0);
        check("t4_in_hold", ov_seen, 1);
        cycle();
        check("t4_ack_after_rd", a_took, 1);
        a_req = 1'b0;
        drain("t3");

        // Consumer stall for ten cycles.
        a_req = 1'b1; a_data = 16'h5550; out_ready = 1'b0; n = 0; found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (a_took) begin n++; a_data++; if (n == 3) a_req = 1'b0; end
            if (n == 3 && ov_seen) begin found = 1'b1; break; end
        end
        check("t5_reached_hold", found, 1);
        rd_cnt = 0; v = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (rd_seen) rd_cnt++;
            v = v && ov_seen;
        end
        check("t5_no_read", rd_cnt, 0);
        check("t5_valid_held", v, 1);
        check("t5_data", out_data, 16'h5550);
        drain("t5");

        // Random traffic.
        for (int k = 0; k < 1500; k++) begin
            cycle();
            if (!a_req || a_took) begin a_req = ($urandom_range(0, 99) < 60); a_data = 16'($urandom); end
            if (!b_req || b_took) begin b_req = ($urandom_range(0, 99) < 60); b_data = 16'($urandom); end
            out_ready = ($urandom_range(0, 99) < ((k < 750) ? 70 : 20));
        end
        drain("rand");

        // Forced left_sig disagreement.
        do_reset();
        a_req = 1'b1; a_data = 16'h6000; n = 0;
        for (int k = 0; k < 30; k++) begin
            cycle();
            if (a_took) begin n++; a_data++; if (n == 4) a_req = 1'b0; end
        end
        check("t6_occ3", occ, 3);
        sync_expect = 1'b1;
        force_left = 1'b1;
        cycle();
        force_left = 1'b0;
        check("t6_sync_err_set", sync_err, 1);
        cycle();
        check("t6_sync_err_sticky", sync_err, 1);
        do_reset();
        sync_expect = 1'b0;
        check("t6_sync_err_cleared", sync_err, 0);

        // Reset while the FSM is in CAP.
        a_req = 1'b1; a_data = 16'h7777; found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (a_took) a_req = 1'b0;
            if (rd_seen) begin found = 1'b1; break; end
        end
        check("t7_reached_rd", found, 1);
        rst_n = 1'b1;
        cycle();
        rst_n = 1'b0;
        check("t7_out_valid", out_valid, 0);
        check("t7_occ", occ, 0);
        check("t7_rd_req", fifo_read_req, 0);
        out_ready = 1'b1; n = 0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (ov_seen) n++;
        end
        check("t7_word_dropped", n, 0);

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
